alu_result_stage: RTL and testbench

//  Execute->writeback pipeline stage directly downstream of the 8-bit ALU. Captures ALU OUT/OVERFLOW/ZF

---
 rtl/alu_result_stage_pkg.sv | 31 +++
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/result_fifo2.sv | 62 ++++++
 rtl/alu_result_stage.sv | 77 +++++++
 tb/tb_alu_result_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared CPU definitions for the execute->writeback path: widths, ALU opcodes,
// and the buffered result entry format.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int OVF_W   = 2;
  localparam int RADDR_W = 3;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_XOR = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_ADD = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [OVF_W-1:0]   ovf;
    logic               zf;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               setf;
  } res_entry_t;

  // Encodings above OP_ADD are reserved and must not write architectural state.
  function automatic logic op_is_valid(input logic [2:0] op);
    return op <= 3'(OP_ADD);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU (producer), the result stage, and the
// register-file write port (consumer).
interface alu_result_stage_if;
  import cpu_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [DATA_W-1:0]  in_result;
  logic [OVF_W-1:0]   in_ovf;
  logic               in_zf;
  logic [RADDR_W-1:0] in_rd;
  logic               in_we;
  logic               in_setf;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_result;
  logic [RADDR_W-1:0] out_rd;
  logic               out_we;

  modport master (
    output in_valid, in_op, in_result, in_ovf, in_zf, in_rd, in_we, in_setf, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_op, in_result, in_ovf, in_zf, in_rd, in_we, in_setf, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we
  );

endinterface

// File: rtl/result_fifo2.sv
// Two-entry in-order result buffer with synchronous flush and a youngest-writer
// forwarding select. push/pop arrive already qualified by the caller.
module result_fifo2
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  res_entry_t         wr_entry,
  output res_entry_t         head_entry,
  output logic [1:0]         count,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data
);

  res_entry_t mem [2];
  logic       head_ptr;
  logic       tail_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= wr_entry;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_entry = mem[head_ptr];

  // The youngest entry sits just behind tail; with one entry that is also the head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = mem[~tail_ptr].rd;
    fwd_data  = mem[~tail_ptr].result;
    if (count != 2'd0 && mem[~tail_ptr].we) begin
      fwd_valid = 1'b1;
    end else if (count == 2'd2 && mem[head_ptr].we) begin
      fwd_valid = 1'b1;
      fwd_rd    = mem[head_ptr].rd;
      fwd_data  = mem[head_ptr].result;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute->writeback stage: buffers ALU results, retires them to the register
// file in order, and owns the architectural ZF/OVERFLOW flag register.
module alu_result_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_result_stage_if.slave  bus,
  output logic               flag_zf,
  output logic [OVF_W-1:0]   flag_ovf,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               op_err
);

  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       op_ok;
  res_entry_t wr_entry;
  res_entry_t head_entry;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);

  // Flush wins over both sides, so neither a push nor a flag retire happens that cycle.
  assign push  = bus.in_valid & bus.in_ready & ~flush;
  assign pop   = bus.out_valid & bus.out_ready & ~flush;
  assign op_ok = op_is_valid(bus.in_op);

  always_comb begin
    wr_entry.result = bus.in_result;
    wr_entry.ovf    = bus.in_ovf;
    wr_entry.zf     = bus.in_zf;
    wr_entry.rd     = bus.in_rd;
    wr_entry.we     = bus.in_we & op_ok;
    wr_entry.setf   = bus.in_setf & op_ok;
  end

  result_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (count),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data)
  );

  assign bus.out_result = head_entry.result;
  assign bus.out_rd     = head_entry.rd;
  assign bus.out_we     = bus.out_valid & head_entry.we;

  // Flags follow retirement, and op_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zf  <= 1'b0;
      flag_ovf <= '0;
      op_err   <= 1'b0;
    end else begin
      if (pop && head_entry.setf) begin
        flag_zf  <= head_entry.zf;
        flag_ovf <= head_entry.ovf;
      end
      if (push && !op_ok) begin
        op_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               flag_zf;
  logic [OVF_W-1:0]   flag_ovf;
  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]  fwd_data;
  logic               op_err;

  int total = 0;
  int bad   = 0;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .flag_zf   (flag_zf),
    .flag_ovf  (flag_ovf),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .op_err    (op_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [7:0] result,
                               input logic [1:0] ovf, input logic zf, input logic [2:0] rd,
                               input logic we, input logic setf);
    bus.in_valid  = valid;
    bus.in_op     = op;
    bus.in_result = result;
    bus.in_ovf    = ovf;
    bus.in_zf     = zf;
    bus.in_rd     = rd;
    bus.in_we     = we;
    bus.in_setf   = setf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    #12;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_fwd_valid", 32'(fwd_valid),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] ADD 255+255 retire");
    applyStimulus(1'b1, 3'd4, 8'hFE, 2'b01, 1'b0, 3'd3, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("add_out_valid",  32'(bus.out_valid),  32'd1);
    checkOutput("add_out_result", 32'(bus.out_result), 32'hFE);
    checkOutput("add_out_rd",     32'(bus.out_rd),     32'd3);
    checkOutput("add_out_we",     32'(bus.out_we),     32'd1);
    checkOutput("add_fwd",        {fwd_valid, 20'd0, fwd_rd, fwd_data}, {1'b1, 20'd0, 3'd3, 8'hFE});
    checkOutput("add_flag_early", 32'(flag_ovf),       32'd0);
    tick();
    checkOutput("add_flag_ovf",   32'(flag_ovf),       32'd1);
    checkOutput("add_flag_zf",    32'(flag_zf),        32'd0);
    checkOutput("add_drained",    32'(bus.out_valid),  32'd0);

    $display("[TB] backpressure A,B,C");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd0, 8'h11, 2'b00, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd1, 8'h22, 2'b00, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    checkOutput("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_fwd_data_B",    32'(fwd_data),     32'h22);
    checkOutput("bp_fwd_rd_B",      32'(fwd_rd),       32'd2);
    applyStimulus(1'b1, 3'd2, 8'h33, 2'b00, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    checkOutput("bp_head_A",        32'(bus.out_result), 32'h11);
    checkOutput("bp_c_held",        32'(bus.in_ready),   32'd0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_head_B",        32'(bus.out_result), 32'h22);
    checkOutput("bp_ready_again",   32'(bus.in_ready),   32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("bp_head_C",        32'(bus.out_result), 32'h33);
    checkOutput("bp_head_C_rd",     32'(bus.out_rd),     32'd4);
    tick();
    checkOutput("bp_empty",         32'(bus.out_valid),  32'd0);
    checkOutput("bp_flags_kept",    32'(flag_ovf),       32'd1);

    $display("[TB] push and pop together at count 1");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd4, 8'h44, 2'b10, 1'b0, 3'd5, 1'b1, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'd3, 8'h55, 2'b00, 1'b1, 3'd6, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("pp_out_valid",  32'(bus.out_valid),  32'd1);
    checkOutput("pp_in_ready",   32'(bus.in_ready),   32'd1);
    checkOutput("pp_head_E",     32'(bus.out_result), 32'h55);
    checkOutput("pp_flag_ovf",   32'(flag_ovf),       32'd2);
    tick();
    checkOutput("pp_count0",     32'(bus.out_valid),  32'd0);
    checkOutput("pp_flags_keep", {flag_zf, flag_ovf}, {1'b0, 2'b10});

    $display("[TB] invalid opcode");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd7, 8'h66, 2'b11, 1'b1, 3'd7, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("bad_op_head",   32'(bus.out_valid), 32'd1);
    checkOutput("bad_op_we",     32'(bus.out_we),    32'd0);
    checkOutput("bad_op_err",    32'(op_err),        32'd1);
    checkOutput("bad_op_nofwd",  32'(fwd_valid),     32'd0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bad_op_flags",  {flag_zf, flag_ovf}, {1'b0, 2'b10});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("bad_op_sticky", 32'(op_err),        32'd1);

    $display("[TB] flush at count 2");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd4, 8'h77, 2'b11, 1'b1, 3'd1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd4, 8'h88, 2'b11, 1'b1, 3'd2, 1'b1, 1'b1);
    tick();
    checkOutput("fl_full",       32'(bus.in_ready),  32'd0);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 3'd0, 8'h99, 2'b00, 1'b0, 3'd3, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("fl_out_valid",  32'(bus.out_valid), 32'd0);
    checkOutput("fl_in_ready",   32'(bus.in_ready),  32'd1);
    checkOutput("fl_flags",      {flag_zf, flag_ovf}, {1'b0, 2'b10});
    checkOutput("fl_fwd",        32'(fwd_valid),     32'd0);

    $display("[TB] reset mid-traffic");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd4, 8'hAA, 2'b01, 1'b0, 3'd5, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 3'd4, 8'hBB, 2'b01, 1'b0, 3'd6, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("mr_full",       32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_out_valid",  32'(bus.out_valid),  32'd0);
    checkOutput("mr_flags",      {flag_zf, flag_ovf}, 3'b000);
    checkOutput("mr_op_err",     32'(op_err),         32'd0);
    checkOutput("mr_payload",    32'(bus.out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mr_in_ready",   32'(bus.in_ready),   32'd1);
    checkOutput("mr_still_empty",32'(bus.out_valid),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
